// File: rtl/debug_loader.sv
// debug_loader: takes a 2-byte word-count header and little-endian 32-bit words from the
// debug UART and writes them into program memory. The CPU is stalled for the whole load.
module debug_loader #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data1,
  output logic [31:0]       mem_data2,
  output logic              mem_web,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int CW = ADDR_W + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [CW-1:0] IDX_ONE   = CW'(1);

  logic [2:0]    state;
  logic [7:0]    count_lo;
  logic [CW-1:0] word_count;
  logic [CW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [TW-1:0] tcnt;
  logic          xfer;
  logic          bad_count;

  // rx_ready is already high exactly in the byte-accepting states
  assign xfer      = rx_valid && rx_ready;
  assign bad_count = ({1'b0, rx_data, count_lo} == 17'd0) ||
                     ({1'b0, rx_data, count_lo} > MAX_WORDS);
  assign mem_data2 = 32'h0;
  assign cpu_stall = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count_lo    <= 8'h0;
      word_count  <= '0;
      word_idx    <= '0;
      byte_idx    <= 2'd0;
      word_buf    <= 24'h0;
      tcnt        <= '0;
      rx_ready    <= 1'b0;
      mem_address <= '0;
      mem_data1   <= 32'h0;
      mem_web     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_web <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_HDR0;
            done     <= 1'b0;
            error    <= 1'b0;
            byte_idx <= 2'd0;
            word_idx <= '0;
            tcnt     <= '0;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
          end
        end
        S_HDR0, S_HDR1, S_DATA: begin
          if (xfer) begin
            tcnt <= '0;
            if (state == S_HDR0) begin
              count_lo <= rx_data;
              state    <= S_HDR1;
            end else if (state == S_HDR1) begin
              if (bad_count) begin
                state    <= S_ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
                rx_ready <= 1'b0;
              end else begin
                word_count <= CW'({rx_data, count_lo});
                state      <= S_DATA;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              word_buf <= {rx_data, word_buf[23:8]};
              // Fourth byte goes straight into the write data register
              if (byte_idx == 2'd3) begin
                state       <= S_WRITE;
                mem_web     <= 1'b0;
                mem_address <= word_idx[ADDR_W-1:0];
                mem_data1   <= {rx_data, word_buf};
                rx_ready    <= 1'b0;
              end
            end
          end else if (tcnt == T_LIMIT) begin
            state    <= S_ERROR;
            error    <= 1'b1;
            busy     <= 1'b0;
            rx_ready <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + IDX_ONE;
          tcnt     <= '0;
          if (word_idx + IDX_ONE == word_count) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: randomized loads compared against a word-list reference model of the
// loader, plus header errors, timeout, mid-load reset and restart behaviour.
module tb_debug_loader;

  localparam int ADDR_W   = 11;
  localparam int TIMEOUT  = 40;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] rxData = 8'h0;
  logic rxValid = 1'b0;
  logic rxReady;
  logic [ADDR_W-1:0] memAddress;
  logic [31:0] memData1;
  logic [31:0] memData2;
  logic memWeb;
  logic cpuStall;
  logic busy;
  logic done;
  logic error;

  int checks = 0;
  int errors = 0;

  logic [42:0] obsWrites[$];
  logic [42:0] expWrites[$];

  debug_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rxData), .rx_valid(rxValid),
    .rx_ready(rxReady), .mem_address(memAddress), .mem_data1(memData1),
    .mem_data2(memData2), .mem_web(memWeb), .cpu_stall(cpuStall), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every cycle with the strobe low is one memory write; a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (!rst && !memWeb) begin
      obsWrites.push_back({memAddress, memData1});
      checkOutput("mem_data2", memData2, 0);
    end
  end

  task automatic checkIdleOutputs(input string tag, input logic expDone, input logic expError);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_stall"}, cpuStall, 0);
    checkOutput({tag, "_ready"}, rxReady, 0);
    checkOutput({tag, "_web"}, memWeb, 1);
    checkOutput({tag, "_done"}, done, expDone);
    checkOutput({tag, "_error"}, error, expError);
  endtask

  task automatic compareWrites(input string tag);
    checkOutput({tag, "_nwrites"}, obsWrites.size(), expWrites.size());
    for (int i = 0; i < obsWrites.size() && i < expWrites.size(); i++)
      checkOutput({tag, "_write"}, obsWrites[i], expWrites[i]);
    obsWrites.delete();
    expWrites.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_stall", cpuStall, 1);
    checkOutput("start_ready", rxReady, 1);
    checkOutput("start_done_clr", done, 0);
    checkOutput("start_err_clr", error, 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCycles;
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
    rxData = b;
    rxValid = 1'b1;
    waitCycles = 0;
    while (!rxReady && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!rxReady) checkOutput("rx_ready_wait", 0, 1);
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic waitFinished();
    int waitCycles = 0;
    while (!done && !error && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!done && !error) checkOutput("finish_wait", 0, 1);
  endtask

  // Reference model: a header is valid for 1..2^ADDR_W words, word k lands at address k
  task automatic applyStimulus(input string tag, input int count, input int maxGap,
                               input bit seqWords, input bit midStart);
    logic [31:0] w;
    bit valid;
    valid = (count >= 1) && (count <= MEM_SIZE);
    pulseStart();
    sendByte(count[7:0], $urandom_range(maxGap));
    sendByte(count[15:8], $urandom_range(maxGap));
    if (!valid) begin
      @(negedge clk);
      checkIdleOutputs({tag, "_badhdr"}, 0, 1);
      compareWrites({tag, "_badhdr"});
      return;
    end
    for (int k = 0; k < count; k++) begin
      w = seqWords ? 32'(k) : $urandom;
      expWrites.push_back({k[ADDR_W-1:0], w});
      for (int j = 0; j < 4; j++) begin
        if (midStart && k == 0 && j == 2) start = 1'b1;
        sendByte(w[8*j +: 8], $urandom_range(maxGap));
        start = 1'b0;
      end
    end
    waitFinished();
    checkIdleOutputs(tag, 1, 0);
    compareWrites(tag);
  endtask

  initial begin
    logic [31:0] w;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset_hold", 0, 0);
    checkOutput("reset_addr", memAddress, 0);
    checkOutput("reset_data1", memData1, 0);
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset_rel", 0, 0);

    // Start and a byte in the same idle cycle: the byte must not be taken as the header
    rxData = 8'h05;
    rxValid = 1'b1;
    pulseStart();
    rxValid = 1'b0;
    sendByte(8'h02, 0);
    sendByte(8'h00, 0);
    foreach (w[i]) w[i] = 1'b0;
    for (int b = 0; b < 8; b++) sendByte(8'(b * 17 + 3), 0);
    expWrites.push_back({11'd0, 32'h36_25_14_03});
    expWrites.push_back({11'd1, 32'h7A_69_58_47});
    waitFinished();
    checkIdleOutputs("same_cycle", 1, 0);
    compareWrites("same_cycle");

    // Directed N=2 image from the byte stream 02 00 | 78 56 34 12 | EF BE AD DE
    pulseStart();
    sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h78, 0); sendByte(8'h56, 0); sendByte(8'h34, 0); sendByte(8'h12, 0);
    sendByte(8'hEF, 0); sendByte(8'hBE, 0); sendByte(8'hAD, 0); sendByte(8'hDE, 0);
    expWrites.push_back({11'd0, 32'h12345678});
    expWrites.push_back({11'd1, 32'hDEADBEEF});
    waitFinished();
    checkIdleOutputs("directed", 1, 0);
    compareWrites("directed");

    applyStimulus("gap3", 3, 3, 0, 0);
    for (int r = 0; r < 4; r++) applyStimulus("random", $urandom_range(6, 1), $urandom_range(3), 0, 0);
    applyStimulus("mid_start", 3, 1, 0, 1);
    applyStimulus("hdr_zero", 0, 0, 0, 0);
    applyStimulus("hdr_2049", 2049, 0, 0, 0);
    applyStimulus("hdr_big", $urandom_range(65535, 2050), 2, 0, 0);
    applyStimulus("single", 1, 0, 0, 0);

    // Stall after the second byte of word 1: only word 0 may reach memory
    pulseStart();
    sendByte(8'h03, 0); sendByte(8'h00, 0);
    for (int b = 0; b < 6; b++) sendByte(8'(8'hA0 + b), 0);
    expWrites.push_back({11'd0, 32'hA3A2A1A0});
    repeat (TIMEOUT + 5) @(negedge clk);
    checkIdleOutputs("timeout", 0, 1);
    compareWrites("timeout");

    // Reset after 5 of 8 data bytes
    pulseStart();
    sendByte(8'h02, 0); sendByte(8'h00, 0);
    for (int b = 0; b < 5; b++) sendByte(8'(8'h10 + b), 0);
    expWrites.push_back({11'd0, 32'h13121110});
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid_reset", 0, 0);
    checkOutput("mid_reset_addr", memAddress, 0);
    checkOutput("mid_reset_data1", memData1, 0);
    @(negedge clk);
    rst = 1'b0;
    compareWrites("mid_reset");
    applyStimulus("after_reset", 2, 2, 0, 0);

    applyStimulus("full", MEM_SIZE, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
